fifo_uart_tx: RTL and testbench

- Read-side consumer of the team's push/pop FIFO; drains bytes and serialises them as UART 8N1 frames on `tx`.
- Sits between the TX FIFO (`pop`, `pop_data`, `empty`) and the board UART pin.
- The FIFO's `pop_data` is a combinational read at `rptr`, so a byte is captured in the same cycle `pop` is asserted.

---
 rtl/fifo_uart_tx.sv | 118 +++++++++++
 tb/tb_fifo_uart_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Drains a push/pop FIFO and serialises each byte as a UART 8N1 frame.
// Revision : 1.0  initial release
// ============================================================================
module fifo_uart_tx #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD      = 9600,
   parameter int BIT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   input  logic [BIT_WIDTH-1:0] fifo_pop_data,
   output logic                 fifo_pop,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int c_BAUD_DIV = CLK_FREQ / BAUD;
   localparam int c_CNT_W    = (c_BAUD_DIV > 2) ? $clog2(c_BAUD_DIV) : 1;
   localparam int c_BIT_W    = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;

   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_BAUD_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_DONE = c_CNT_W'(c_BAUD_DIV - 2);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(BIT_WIDTH - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_DATA  = 2'd2;
   localparam logic [1:0] c_STOP  = 2'd3;

   logic [1:0]           r_state;
   logic [c_CNT_W-1:0]   r_baud_cnt;
   logic [c_BIT_W-1:0]   r_bit_cnt;
   logic [BIT_WIDTH-1:0] r_shift;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_bit_end;
   logic [BIT_WIDTH-1:0] w_shift_nxt;

   assign w_bit_end   = (r_baud_cnt == c_CNT_LAST);
   assign w_shift_nxt = r_shift >> 1;

   // Gated by rst so a held reset never strobes the FIFO even though state reads IDLE.
   assign fifo_pop = rst & (r_state == c_IDLE) & ~fifo_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= c_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_baud_cnt <= r_baud_cnt + 1'b1;
         case (r_state)
            c_IDLE: begin
               r_baud_cnt <= '0;
               if (fifo_pop) begin
                  r_shift <= fifo_pop_data;
                  r_state <= c_START;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            c_START: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_state    <= c_DATA;
                  r_tx       <= r_shift[0];
               end
            end
            c_DATA: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_shift    <= w_shift_nxt;
                  r_bit_cnt  <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == c_BIT_LAST) begin
                     r_state <= c_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_tx    <= w_shift_nxt[0];
                  end
               end
            end
            c_STOP: begin
               // Registered one cycle ahead so the pulse lands on the final STOP cycle.
               if (r_baud_cnt == c_CNT_DONE) begin
                  r_done <= 1'b1;
               end
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_state    <= c_IDLE;
                  r_busy     <= 1'b0;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign tx      = r_tx;
   assign tx_busy = r_busy;
   assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Directed self-checking bench for fifo_uart_tx with a DEPTH=4 FIFO model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       fifo_pop;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;
   logic       push = 1'b0;
   logic [7:0] push_data = 8'h00;

   logic [7:0] mem [4];
   logic [1:0] wp = 2'd0;
   logic [1:0] rp = 2'd0;
   logic [2:0] cnt = 3'd0;
   logic       fifo_empty;
   logic       fifo_full;
   logic [7:0] fifo_pop_data;

   int         pop_cnt = 0;
   int         n_total = 0;
   int         n_pass  = 0;
   logic [7:0] pend [$];
   logic       empty_k1;
   logic       full_k1;

   always #5 clk = ~clk;

   fifo_uart_tx #(.CLK_FREQ(100), .BAUD(10), .BIT_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty    (fifo_empty),
      .fifo_pop_data (fifo_pop_data),
      .fifo_pop      (fifo_pop),
      .tx            (tx),
      .tx_busy       (tx_busy),
      .tx_done       (tx_done)
   );

   // Team FIFO behaviour: registered flags, combinational read at rp.
   assign fifo_empty    = (cnt == 3'd0);
   assign fifo_full     = (cnt == 3'd4);
   assign fifo_pop_data = mem[rp];

   always @(posedge clk) begin
      logic do_push;
      logic do_pop;
      do_push = push && (cnt != 3'd4);
      do_pop  = fifo_pop && (cnt != 3'd0);
      if (do_push) begin
         mem[wp] <= push_data;
         wp      <= wp + 2'd1;
      end
      if (do_pop) rp <= rp + 2'd1;
      cnt <= cnt + 3'(do_push) - 3'(do_pop);
      if (fifo_pop) pop_cnt <= pop_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      if (pend.size() > 0) begin
         push      = 1'b1;
         push_data = pend.pop_front();
      end else begin
         push = 1'b0;
      end
   endtask

   task automatic wait_pop(input int budget, input string tag);
      int n = 0;
      while (fifo_pop !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(fifo_pop), 32'd1);
   endtask

   // Entered at the negedge before the pop edge; leaves at the following IDLE cycle.
   task automatic check_frame(input logic [7:0] b, input string tag);
      int         tx_errs  = 0;
      int         done_cnt = 0;
      int         done_at  = 0;
      int         busy_cnt = 0;
      int         pops     = 0;
      logic [7:0] dec      = 8'h00;
      logic       exp_tx;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (k == 1) begin
            empty_k1 = fifo_empty;
            full_k1  = fifo_full;
         end
         if (k <= 10)      exp_tx = 1'b0;
         else if (k <= 90) exp_tx = b[(k - 11) / 10];
         else              exp_tx = 1'b1;
         if (tx !== exp_tx) tx_errs++;
         if (tx_done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         if (tx_busy === 1'b1) busy_cnt++;
         if (fifo_pop !== 1'b0) pops++;
         if (k >= 15 && k <= 85 && (k % 10) == 5) dec[(k - 15) / 10] = tx;
      end
      chk({tag, "_tx_errs"},   32'(tx_errs),  32'd0);
      chk({tag, "_decoded"},   32'(dec),      32'(b));
      chk({tag, "_done_cnt"},  32'(done_cnt), 32'd1);
      chk({tag, "_done_at"},   32'(done_at),  32'd100);
      chk({tag, "_busy_cyc"},  32'(busy_cnt), 32'd100);
      chk({tag, "_pop_mid"},   32'(pops),     32'd0);
      step();
      chk({tag, "_idle_tx"},   32'(tx),       32'd1);
      chk({tag, "_idle_busy"}, 32'(tx_busy),  32'd0);
   endtask

   initial begin
      int p0;
      int errs_pop;
      int errs_tx;
      int errs_done;

      // Reset held while the FIFO already has data.
      step();
      pend.push_back(8'hA5);
      step();
      step();
      chk("rst_empty", 32'(fifo_empty), 32'd0);
      chk("rst_tx",    32'(tx),         32'd1);
      chk("rst_pop",   32'(fifo_pop),   32'd0);
      chk("rst_busy",  32'(tx_busy),    32'd0);
      chk("rst_done",  32'(tx_done),    32'd0);
      rst = 1'b1;
      #1;
      chk("rel_pop", 32'(fifo_pop), 32'd1);

      p0 = pop_cnt;
      check_frame(8'hA5, "a5");
      chk("a5_pops",  32'(pop_cnt - p0), 32'd1);
      chk("a5_empty", 32'(fifo_empty),   32'd1);
      chk("a5_nopop", 32'(fifo_pop),     32'd0);

      // Back-to-back frames, then fill the FIFO while 0x3C is on the line.
      pend.push_back(8'h00);
      pend.push_back(8'hFF);
      pend.push_back(8'h3C);
      wait_pop(20, "b2b_wait");
      p0 = pop_cnt;
      check_frame(8'h00, "b00");
      chk("b2b_pop2", 32'(fifo_pop), 32'd1);
      check_frame(8'hFF, "bff");
      chk("b2b_pop3", 32'(fifo_pop), 32'd1);
      pend.push_back(8'h11);
      pend.push_back(8'h22);
      pend.push_back(8'h33);
      pend.push_back(8'h44);
      check_frame(8'h3C, "b3c");
      chk("b2b_empty_3rd", 32'(empty_k1),      32'd1);
      chk("b2b_pops",      32'(pop_cnt - p0),  32'd3);
      chk("fill_full",     32'(fifo_full),     32'd1);

      chk("fill_pop1", 32'(fifo_pop), 32'd1);
      p0 = pop_cnt;
      check_frame(8'h11, "f11");
      chk("fill_full_after_pop", 32'(full_k1), 32'd0);
      chk("fill_pop2", 32'(fifo_pop), 32'd1);
      check_frame(8'h22, "f22");
      chk("fill_pop3", 32'(fifo_pop), 32'd1);
      check_frame(8'h33, "f33");
      chk("fill_pop4", 32'(fifo_pop), 32'd1);
      check_frame(8'h44, "f44");
      chk("fill_empty", 32'(fifo_empty), 32'd1);
      for (int i = 0; i < 30; i++) step();
      chk("fill_pops", 32'(pop_cnt - p0), 32'd4);

      // Reset in the middle of DATA bit 3 of 0x55.
      pend.push_back(8'h55);
      wait_pop(20, "mid_wait");
      p0 = pop_cnt;
      for (int k = 1; k <= 45; k++) step();
      chk("mid_bit3_pre", 32'(tx), 32'd0);
      rst = 1'b0;
      #1;
      chk("mid_rst_tx",   32'(tx),       32'd1);
      chk("mid_rst_busy", 32'(tx_busy),  32'd0);
      chk("mid_rst_pop",  32'(fifo_pop), 32'd0);
      pend.push_back(8'h66);
      errs_pop = 0;
      errs_tx  = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (fifo_pop !== 1'b0) errs_pop++;
         if (tx !== 1'b1) errs_tx++;
      end
      chk("mid_hold_pop", 32'(errs_pop), 32'd0);
      chk("mid_hold_tx",  32'(errs_tx),  32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rel_pop", 32'(fifo_pop), 32'd1);
      check_frame(8'h66, "m66");
      chk("mid_pops", 32'(pop_cnt - p0), 32'd2);

      // Starvation.
      errs_pop  = 0;
      errs_tx   = 0;
      errs_done = 0;
      for (int i = 0; i < 500; i++) begin
         step();
         if (fifo_pop !== 1'b0) errs_pop++;
         if (tx !== 1'b1) errs_tx++;
         if (tx_done !== 1'b0) errs_done++;
      end
      chk("starve_pop",  32'(errs_pop),  32'd0);
      chk("starve_tx",   32'(errs_tx),   32'd0);
      chk("starve_done", 32'(errs_done), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
